demux_reg: RTL and testbench
============================

Name: demux_reg

Overview:
- Registered 1-to-2**SELECT_LINES demultiplexer; the write-side counterpart of the library mux.
- Steers a DATA_WIDTH input word into one slot of a flat output bus and holds it there.
- Tracks per-slot valid bits and a sticky overwrite flag, and pulses frame_done when every slot has been filled.
- Sits between a narrow word stream and wide parallel consumers (register banks, mux inputs).

Parameters:
SELECT_LINES  4  number of select bits; NUM_SLOTS = 2**SELECT_LINES
DATA_WIDTH    2  width of one slot/word in bits

Ports:
clk         input   1                         rising-edge clock
rst_n       input   1                         asynchronous active-low reset
in_valid    input   1                         write strobe; one word captured per cycle when high
select      input   SELECT_LINES              target slot index (ignored when DEMUX_AUTO_INC_EN defined)
data_in     input   DATA_WIDTH                word to store
clear       input   1                         synchronous clear of valid bits, overwrite flag and pointer
data_out    output  DATA_WIDTH*NUM_SLOTS      slot s occupies bits [s*DATA_WIDTH +: DATA_WIDTH]
slot_valid  output  NUM_SLOTS                 bit s set once slot s written since last clear
overwrite   output  1                         sticky; set when writing a slot whose valid bit is already set
frame_done  output  1                         one-cycle pulse when slot_valid becomes all ones

Behaviour:
- Reset (rst_n low, async): data_out=0, slot_valid=0, overwrite=0, frame_done=0, internal wr_ptr=0. Outputs hold these values until the first clk edge after rst_n deasserts.
- Write (in_valid=1 at edge): slot s=select (or wr_ptr) gets data_in; slot_valid[s]<=1. Latency is 1 cycle: data appears on data_out at the edge that samples in_valid. All other slots are unchanged.
- Overwrite: if slot_valid[s] is already 1 at a write, data is replaced and overwrite<=1. The flag stays set until clear or reset.
- frame_done <= in_valid & (slot_valid_next == all ones) & (slot_valid != all ones). It is high for exactly one cycle, coincident with slot_valid reaching all ones. Further writes while full produce no additional pulse.
- clear=1, in_valid=0: slot_valid<=0, overwrite<=0, wr_ptr<=0. data_out is retained.
- clear=1 with in_valid=1 in the same cycle:
  - Clear applies first, then the write.
  - Result: slot_valid has only bit s set, data is written, overwrite=0.
  - frame_done fires only if NUM_SLOTS==1.
  - In auto mode, the write goes to slot 0 and wr_ptr<=1.
- in_valid=0, clear=0: all state holds.
- Reset mid-frame: all state returns to reset values immediately, with no pulse.
- Width rules: select and wr_ptr are SELECT_LINES bits and are unsigned. Any select value is legal (full range).

Optional Feature:
- Macro DEMUX_AUTO_INC_EN.
- Defined:
  - select is ignored; the internal wr_ptr addresses the slot.
  - wr_ptr increments by 1 on each write and wraps from NUM_SLOTS-1 to 0.
  - clear sets wr_ptr to 0.
  - Filling all slots in order gives frame_done on write NUM_SLOTS with no overwrite. Write NUM_SLOTS+1 (slot 0 again) sets overwrite unless a clear occurred.
- Not defined: no wr_ptr register; addressing is purely by select.

Decomposition:
- Shared constants include file demux_defs.vh: NUM_SLOTS derivation (2**SELECT_LINES) and slot bit-slice offset macro. The same include is reusable by mux.
- Sub-module demux_slot: one DATA_WIDTH data register plus valid bit, with inputs wr_en/clear/data_in and outputs data/valid/ovw_hit. It is generated NUM_SLOTS times.
- The top level holds select decode, wr_ptr, overwrite, frame_done.

Test Plan (SELECT_LINES=4, DATA_WIDTH=2):
- Reset then idle: data_out==0, slot_valid==16'h0000, overwrite==0, frame_done never high.
- Write select=3, data_in=2'b10 -> next cycle data_out[7:6]==2'b10, slot_valid==16'h0008, all other slots 0.
- Write slots 0..15 with data s[1:0] -> data_out==32'hE4E4E4E4, slot_valid==16'hFFFF, frame_done high exactly on the 16th write edge only.
- Write select=5 twice (01 then 11) -> data_out[11:10]==2'b11, overwrite==1 and stays 1; then clear -> slot_valid==0, overwrite==0, data_out unchanged.
- clear and in_valid together with select=7, data_in=01 -> slot_valid==16'h0080, overwrite==0, data_out[15:14]==01.
- DEMUX_AUTO_INC_EN:
  - 17 writes with select=0 -> slots fill 0..15, frame_done on write 16, write 17 lands in slot 0 with overwrite==1.
  - Assert rst_n low mid-sequence -> all outputs 0 immediately; the next write goes to slot 0.

Source files
------------

// File: rtl/demux_reg_pkg.sv
// Shared constants and helpers for the registered demultiplexer.
// The mux can import the same slot-count and slot-offset helpers.
package demux_reg_pkg;

  localparam int DEF_SELECT_LINES = 4;
  localparam int DEF_DATA_WIDTH   = 2;

  // Number of slots addressed by a select field of sel_lines bits.
  function automatic int num_slots(input int sel_lines);
    return 1 << sel_lines;
  endfunction

  // LSB position of a slot inside the flat output bus.
  function automatic int slot_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One demux slot: a data word plus its valid bit.
// ovw_hit flags a write landing on an already-valid slot. A write that
// coincides with clear is not an overwrite, because clear applies first.
module demux_slot #(
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  ovw_hit
);

  assign ovw_hit = wr_en & valid & ~clear;

  // Capture the word on write. The valid bit is cleared first, then set by
  // any write in the same cycle. Data survives clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_en) data <= data_in;
      if (clear) valid <= wr_en;
      else if (wr_en) valid <= 1'b1;
    end
  end

endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2**SELECT_LINES demultiplexer with per-slot valid bits,
// a sticky overwrite flag and a frame_done pulse.
// Optional macro DEMUX_AUTO_INC_EN: slots are addressed by an internal
// wrapping write pointer instead of select.
module demux_reg
  import demux_reg_pkg::*;
#(
  parameter  int SELECT_LINES = DEF_SELECT_LINES,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int NUM_SLOTS    = num_slots(SELECT_LINES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [SELECT_LINES-1:0]         select,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            clear,
  output logic [DATA_WIDTH*NUM_SLOTS-1:0] data_out,
  output logic [NUM_SLOTS-1:0]            slot_valid,
  output logic                            overwrite,
  output logic                            frame_done
);

  logic [SELECT_LINES-1:0] slot_sel;
  logic [NUM_SLOTS-1:0]    wr_en;
  logic [NUM_SLOTS-1:0]    base_valid;
  logic [NUM_SLOTS-1:0]    valid_next;
  logic [NUM_SLOTS-1:0]    ovw_hit;

`ifdef DEMUX_AUTO_INC_EN
  logic [SELECT_LINES-1:0] wr_ptr;
  logic                    unused_select;

  assign unused_select = ^select;
  // A clear in the same cycle rewinds the pointer before the write uses it.
  assign slot_sel = clear ? '0 : wr_ptr;

  // Write pointer: advances per write, wraps naturally, rewinds on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= in_valid ? SELECT_LINES'(1) : '0;
    end else if (in_valid) begin
      wr_ptr <= wr_ptr + SELECT_LINES'(1);
    end
  end
`else
  assign slot_sel = select;
`endif

  // Decode the target slot and predict the valid vector after this edge.
  always_comb begin
    wr_en = '0;
    if (in_valid) wr_en[slot_sel] = 1'b1;
    base_valid = clear ? '0 : slot_valid;
    valid_next = base_valid | wr_en;
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[s]),
      .clear   (clear),
      .data_in (data_in),
      .data    (data_out[slot_lsb(s, DATA_WIDTH) +: DATA_WIDTH]),
      .valid   (slot_valid[s]),
      .ovw_hit (ovw_hit[s])
    );
  end

  // Sticky overwrite flag and one-shot frame_done on the transition to full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overwrite  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      overwrite  <= clear ? 1'b0 : (overwrite | (|ovw_hit));
      frame_done <= in_valid & (&valid_next) & ~(&base_valid);
    end
  end

endmodule

// File: tb/tb_demux_reg.sv
// Scoreboard bench for demux_reg (SELECT_LINES=4, DATA_WIDTH=2).
// Stimulus pushes the expected post-edge state; a negedge monitor pops and
// compares. Key points are also checked directly against literal values.
module tb_demux_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  select = '0;
  logic [1:0]  data_in = '0;
  logic        clear = 1'b0;
  logic [31:0] data_out;
  logic [15:0] slot_valid;
  logic        overwrite;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] v;
    logic        o;
    logic        f;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_data;
  logic [15:0] m_valid;
  logic        m_ovw;
  logic        m_fd;
  logic [3:0]  m_ptr;

  demux_reg #(.SELECT_LINES(4), .DATA_WIDTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .select     (select),
    .data_in    (data_in),
    .clear      (clear),
    .data_out   (data_out),
    .slot_valid (slot_valid),
    .overwrite  (overwrite),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new state every edge; compare it to the queue.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_data_out", data_out, e.d);
      chk("sb_slot_valid", {16'h0, slot_valid}, {16'h0, e.v});
      chk("sb_overwrite", {31'h0, overwrite}, {31'h0, e.o});
      chk("sb_frame_done", {31'h0, frame_done}, {31'h0, e.f});
    end
  end

  task automatic model_reset();
    m_data = '0; m_valid = '0; m_ovw = 1'b0; m_fd = 1'b0; m_ptr = '0;
  endtask

  // Expected behaviour of one clock edge.
  task automatic model_step(input logic iv, input logic [3:0] sel,
                            input logic [1:0] d, input logic clr);
    logic [15:0] base;
    logic [15:0] nv;
    logic [3:0]  s;
    base = clr ? 16'h0 : m_valid;
    if (clr) m_ovw = 1'b0;
`ifdef DEMUX_AUTO_INC_EN
    s = clr ? 4'd0 : m_ptr;
`else
    s = sel;
`endif
    m_fd = 1'b0;
    nv = base;
    if (iv) begin
      if (base[s]) m_ovw = 1'b1;
      m_data[s*2 +: 2] = d;
      nv[s] = 1'b1;
      m_fd = (nv == 16'hFFFF) && (base != 16'hFFFF);
      m_ptr = s + 4'd1;
    end else if (clr) begin
      m_ptr = '0;
    end
    m_valid = nv;
  endtask

  // Drive one cycle; returns #1 after the edge with expectation queued.
  task automatic cycle(input logic iv, input logic [3:0] sel,
                       input logic [1:0] d, input logic clr);
    in_valid = iv; select = sel; data_in = d; clear = clr;
    @(posedge clk);
    model_step(iv, sel, d, clr);
    sb.push_back('{d: m_data, v: m_valid, o: m_ovw, f: m_fd});
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_slot_valid", {16'h0, slot_valid}, 32'h0);
    chk("rst_overwrite", {31'h0, overwrite}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (3) cycle(1'b0, 4'd0, 2'd0, 1'b0);

`ifdef DEMUX_AUTO_INC_EN
    for (int k = 0; k < 16; k++) cycle(1'b1, 4'd0, 2'(k), 1'b0);
    chk("auto_full_data", data_out, 32'hE4E4E4E4);
    chk("auto_full_valid", {16'h0, slot_valid}, 32'h0000FFFF);
    chk("auto_full_fd", {31'h0, frame_done}, 32'h1);
    chk("auto_full_ovw", {31'h0, overwrite}, 32'h0);
    cycle(1'b1, 4'd0, 2'b11, 1'b0);
    chk("auto_w17_slot0", {30'h0, data_out[1:0]}, 32'h3);
    chk("auto_w17_ovw", {31'h0, overwrite}, 32'h1);
    chk("auto_w17_fd", {31'h0, frame_done}, 32'h0);
    cycle(1'b1, 4'd9, 2'b01, 1'b1);
    chk("auto_clrwr_valid", {16'h0, slot_valid}, 32'h00000001);
    chk("auto_clrwr_ovw", {31'h0, overwrite}, 32'h0);
    cycle(1'b1, 4'd9, 2'b10, 1'b0);
    chk("auto_after_clr_valid", {16'h0, slot_valid}, 32'h00000003);
    chk("auto_after_clr_data", {28'h0, data_out[3:0]}, 32'h9);
`else
    cycle(1'b1, 4'd3, 2'b10, 1'b0);
    chk("w3_data", data_out, 32'h00000080);
    chk("w3_valid", {16'h0, slot_valid}, 32'h00000008);
    cycle(1'b0, 4'd0, 2'd0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 4'(k), 2'(k), 1'b0);
      if (k == 14) chk("fd_before_full", {31'h0, frame_done}, 32'h0);
    end
    chk("full_data", data_out, 32'hE4E4E4E4);
    chk("full_valid", {16'h0, slot_valid}, 32'h0000FFFF);
    chk("full_fd", {31'h0, frame_done}, 32'h1);
    cycle(1'b0, 4'd0, 2'd0, 1'b0);
    chk("fd_one_cycle", {31'h0, frame_done}, 32'h0);
    cycle(1'b1, 4'd2, 2'b10, 1'b0);
    chk("full_rewrite_fd", {31'h0, frame_done}, 32'h0);
    cycle(1'b0, 4'd0, 2'd0, 1'b1);
    cycle(1'b1, 4'd5, 2'b01, 1'b0);
    cycle(1'b1, 4'd5, 2'b11, 1'b0);
    chk("s5_data", {30'h0, data_out[11:10]}, 32'h3);
    chk("s5_ovw", {31'h0, overwrite}, 32'h1);
    cycle(1'b0, 4'd0, 2'd0, 1'b0);
    chk("s5_ovw_sticky", {31'h0, overwrite}, 32'h1);
    cycle(1'b0, 4'd0, 2'd0, 1'b1);
    chk("clr_valid", {16'h0, slot_valid}, 32'h0);
    chk("clr_ovw", {31'h0, overwrite}, 32'h0);
    chk("clr_data_kept", data_out, 32'hE4E4ECE4);
    cycle(1'b1, 4'd7, 2'b01, 1'b1);
    chk("clrwr_valid", {16'h0, slot_valid}, 32'h00000080);
    chk("clrwr_ovw", {31'h0, overwrite}, 32'h0);
    chk("clrwr_data", {30'h0, data_out[15:14]}, 32'h1);
    chk("clrwr_fd", {31'h0, frame_done}, 32'h0);
`endif

    // Reset in the middle of a frame, then resume.
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'(k), 2'b11, 1'b0);
    do_reset();
    cycle(1'b1, 4'd9, 2'b10, 1'b0);
`ifdef DEMUX_AUTO_INC_EN
    chk("post_rst_valid", {16'h0, slot_valid}, 32'h00000001);
    chk("post_rst_data", data_out, 32'h00000002);
`else
    chk("post_rst_valid", {16'h0, slot_valid}, 32'h00000200);
    chk("post_rst_data", data_out, 32'h00080000);
`endif
    repeat (2) cycle(1'b0, 4'd0, 2'd0, 1'b0);

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
